hough_accumulator: RTL and testbench

Vote accumulation stage of the Hough transform. It owns the port side of one accumulator `bram` instance (depth `IMAGE_SIZE`, taken from `globals.sv`). On `start` it zero-clears every bin. It then accepts a stream of bin addresses over a valid/ready handshake and performs a saturating read-modify-write increment per vote at one vote per cycle. Downstream peak detection reads the `bram` only after `done` rises.

---
 rtl/hough_accumulator.sv | 140 ++++++++++++++
 tb/tb_hough_accumulator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hough_accumulator.sv
// Hough vote accumulator: zero-clears every bin of the attached BRAM, then
// applies one saturating read-modify-write increment per accepted vote.
module hough_accumulator #(
  parameter int IMAGE_SIZE      = 100,  // depth of the attached bram
  parameter int BRAM_DATA_WIDTH = 8,
  parameter int AW              = $clog2(IMAGE_SIZE)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       vote_valid,
  input  logic [AW-1:0]              vote_addr,
  input  logic                       vote_last,
  output logic                       vote_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       sat_seen,
  output logic [AW-1:0]              bram_rd_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_rd_data,
  output logic [AW-1:0]              bram_wr_addr,
  output logic                       bram_wr_en,
  output logic [BRAM_DATA_WIDTH-1:0] bram_wr_data
);

  typedef enum logic [2:0] {IDLE, CLEAR, VOTE, DRAIN, DONE} state_e;

  localparam logic [AW-1:0]              LAST_ADDR = AW'(IMAGE_SIZE - 1);
  localparam logic [AW-1:0]              ADDR_ONE  = AW'(1);
  localparam logic [BRAM_DATA_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [BRAM_DATA_WIDTH-1:0] CNT_ONE   = BRAM_DATA_WIDTH'(1);

  state_e                     state_q, state_d;
  logic [AW-1:0]              clr_cnt_q, clr_cnt_d;
  logic                       s1_valid_q, s1_valid_d;
  logic [AW-1:0]              s1_addr_q, s1_addr_d;
  logic                       sat_q, sat_d;
  logic                       fwd_valid_q;
  logic [AW-1:0]              fwd_addr_q;
  logic [BRAM_DATA_WIDTH-1:0] fwd_data_q;

  logic                       start_ok;
  logic                       vote_hs;
  logic                       s1_write;
  logic [BRAM_DATA_WIDTH-1:0] old_cnt;
  logic [BRAM_DATA_WIDTH-1:0] new_cnt;

  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign vote_hs  = (state_q == VOTE) && vote_valid;
  assign sat_seen = sat_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = CLEAR;
      CLEAR:      if (clr_cnt_q == LAST_ADDR) state_d = VOTE;
      VOTE:       if (vote_valid && vote_last) state_d = DRAIN;
      DRAIN:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // NOTE: every output gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    vote_ready   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    bram_rd_addr = '0;
    bram_wr_en   = 1'b0;
    bram_wr_addr = '0;
    bram_wr_data = '0;
    unique case (state_q)
      CLEAR: begin
        busy         = 1'b1;
        bram_wr_en   = 1'b1;
        bram_wr_addr = clr_cnt_q;
      end
      VOTE: begin
        busy         = 1'b1;
        vote_ready   = 1'b1;
        bram_rd_addr = vote_addr;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
    if (s1_write) begin
      bram_wr_en   = 1'b1;
      bram_wr_addr = s1_addr_q;
      bram_wr_data = new_cnt;
    end
  end

  // The forwarded copy of the previous write hides the bram's one-cycle
  // read latency when consecutive votes hit the same bin.
  always_comb begin
    old_cnt = bram_rd_data;
    if (fwd_valid_q && (fwd_addr_q == s1_addr_q)) old_cnt = fwd_data_q;
    new_cnt    = (old_cnt == CNT_MAX) ? CNT_MAX : old_cnt + CNT_ONE;
    s1_write   = s1_valid_q && (s1_addr_q <= LAST_ADDR);
    s1_valid_d = vote_hs;
    s1_addr_d  = vote_hs ? vote_addr : s1_addr_q;

    clr_cnt_d = clr_cnt_q;
    if (start_ok)                clr_cnt_d = '0;
    else if (state_q == CLEAR)   clr_cnt_d = clr_cnt_q + ADDR_ONE;

    sat_d = sat_q;
    if (start_ok)                                 sat_d = 1'b0;
    else if (s1_write && (old_cnt == CNT_MAX))    sat_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clr_cnt_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      sat_q       <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      clr_cnt_q   <= clr_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      sat_q       <= sat_d;
      fwd_valid_q <= bram_wr_en;
      fwd_addr_q  <= bram_wr_addr;
      fwd_data_q  <= bram_wr_data;
    end
  end

endmodule

// File: tb/tb_hough_accumulator.sv
// Bench for hough_accumulator: read-first BRAM model, write scoreboard,
// table-driven vote frames and hand-written reset/saturation sequences.
`timescale 1ns/1ps
module tb_hough_accumulator;

  localparam int IMAGE_SIZE = 100;
  localparam int W          = 8;
  localparam int AW         = $clog2(IMAGE_SIZE);
  localparam int CNT_MAX    = (1 << W) - 1;

  typedef struct { int frame; bit v; int addr; bit last; } vote_t;
  typedef struct { int frame; int bin; int exp; } bin_t;
  typedef struct { int addr; int data; } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          vote_valid = 1'b0;
  logic          vote_last = 1'b0;
  logic [AW-1:0] vote_addr = '0;
  logic          vote_ready, busy, done, sat_seen, bram_wr_en;
  logic [AW-1:0] bram_rd_addr, bram_wr_addr;
  logic [W-1:0]  bram_rd_data, bram_wr_data;

  logic [W-1:0]  mem [IMAGE_SIZE];
  int            model [IMAGE_SIZE];
  wr_t           expq [$];
  int            n_checks = 0;
  int            n_errors = 0;

  hough_accumulator #(
    .IMAGE_SIZE      (IMAGE_SIZE),
    .BRAM_DATA_WIDTH (W)
  ) dut (
    .clock        (clk),
    .reset        (rst_n),
    .start        (start),
    .vote_valid   (vote_valid),
    .vote_addr    (vote_addr),
    .vote_last    (vote_last),
    .vote_ready   (vote_ready),
    .busy         (busy),
    .done         (done),
    .sat_seen     (sat_seen),
    .bram_rd_addr (bram_rd_addr),
    .bram_rd_data (bram_rd_data),
    .bram_wr_addr (bram_wr_addr),
    .bram_wr_en   (bram_wr_en),
    .bram_wr_data (bram_wr_data)
  );

  always #5 clk = ~clk;

  // Read-first BRAM: a read colliding with a write returns the old contents.
  // Contents are scrambled while reset is held so only a full clear makes them valid.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < IMAGE_SIZE; i++) mem[i] <= 8'hA5;
    end else begin
      if (int'(bram_rd_addr) < IMAGE_SIZE) bram_rd_data <= mem[bram_rd_addr];
      else                                 bram_rd_data <= 8'hEE;
      if (bram_wr_en && int'(bram_wr_addr) < IMAGE_SIZE) mem[bram_wr_addr] <= bram_wr_data;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every BRAM write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && bram_wr_en) begin
      if (expq.size() == 0) begin
        check("wr_unexpected", bram_wr_en, 0);
      end else begin
        e = expq.pop_front();
        check("wr_addr", bram_wr_addr, e.addr);
        check("wr_data", bram_wr_data, e.data);
      end
    end
  end

  task automatic push_clear();
    for (int i = 0; i < IMAGE_SIZE; i++) begin
      model[i] = 0;
      expq.push_back('{i, 0});
    end
  endtask

  task automatic drive_vote(input bit v, input int addr, input bit last);
    vote_valid = v;
    vote_addr  = AW'(addr);
    vote_last  = last;
    if (v) begin
      check("ready_at_handshake", vote_ready, 1);
      if (addr < IMAGE_SIZE) begin
        model[addr] = (model[addr] == CNT_MAX) ? CNT_MAX : model[addr] + 1;
        expq.push_back('{addr, model[addr]});
      end
    end
    @(posedge clk); #1;
    vote_valid = 1'b0;
    vote_last  = 1'b0;
  endtask

  task automatic do_start(input bit poke_busy);
    int cnt;
    push_clear();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("sat_cleared_on_start", sat_seen, 0);
    check("busy_in_clear", busy, 1);
    cnt = 1;
    while (!vote_ready && cnt < 200) begin
      check("clear_wr_en", bram_wr_en, 1);
      start = (poke_busy && cnt == 10);
      @(posedge clk); #1;
      cnt++;
    end
    start = 1'b0;
    check("ready_latency", cnt, IMAGE_SIZE + 1);
  endtask

  task automatic finish_frame(input bit exp_sat);
    check("drain_busy", busy, 1);
    check("drain_ready", vote_ready, 0);
    check("drain_done", done, 0);
    @(posedge clk); #1;
    check("done_level", done, 1);
    check("done_busy", busy, 0);
    check("done_ready", vote_ready, 0);
    check("sat_seen", sat_seen, exp_sat);
    check("wr_queue_empty", expq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, vote_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sat"}, sat_seen, 0);
    check({tag, "_wr_en"}, bram_wr_en, 0);
    check({tag, "_wr_addr"}, bram_wr_addr, 0);
    check({tag, "_wr_data"}, bram_wr_data, 0);
    check({tag, "_rd_addr"}, bram_rd_addr, 0);
  endtask

  initial begin
    vote_t vtab [14];
    bin_t  btab [14];

    vtab = '{'{0, 1, 5, 0}, '{0, 0, 0, 0}, '{0, 1, 9, 0}, '{0, 0, 0, 0}, '{0, 1, 5, 1},
             '{1, 1, 3, 0}, '{1, 1, 3, 0}, '{1, 1, 3, 0}, '{1, 1, 3, 1},
             '{2, 1, 2, 0}, '{2, 1, IMAGE_SIZE, 0}, '{2, 1, 2, 1},
             '{4, 1, 4, 0}, '{4, 1, IMAGE_SIZE, 1}};
    btab = '{'{0, 5, 2}, '{0, 9, 1}, '{0, 4, 0},
             '{1, 3, 4}, '{1, 5, 0}, '{1, 2, 0},
             '{2, 2, 2}, '{2, 3, 0},
             '{3, 7, CNT_MAX}, '{3, 6, 0}, '{3, 8, 0},
             '{4, 4, 1}, '{4, 7, 0}, '{4, IMAGE_SIZE - 1, 0}};

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    for (int f = 0; f < 5; f++) begin
      if (f == 4) begin
        // Restart from DONE with sat_seen set, then abort mid-clear.
        push_clear();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("sat_cleared_restart", sat_seen, 0);
        repeat (30) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("midclear");
        expq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
      end
      do_start(f == 0);
      if (f == 3) begin
        for (int i = 0; i < 260; i++) drive_vote(1'b1, 7, i == 259);
      end else begin
        foreach (vtab[k])
          if (vtab[k].frame == f) drive_vote(vtab[k].v, vtab[k].addr, vtab[k].last);
      end
      finish_frame(f == 3);
      foreach (btab[k])
        if (btab[k].frame == f) check($sformatf("bin%0d_f%0d", btab[k].bin, f), mem[btab[k].bin], btab[k].exp);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "timeout");
  end

endmodule
